mem_arbiter: RTL

Parametrised N-channel memory request arbiter between the core's requesters (instruction fetch, load/store unit, and later additional masters) and the single-ported main memory. Replaces the single shared grant line with per-channel request/grant/response handshakes, round-robin fairness, and one outstanding transaction tracked to its owning channel. Sits between Fetch/LSU and DRAM in the core top level.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// N-channel memory request arbiter: round-robin grant, one outstanding transaction.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer).
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_ip,
    input  logic [NUM_CH-1:0]            we_ip,
    input  logic [NUM_CH*ADDR_W-1:0]     addr_ip,
    input  logic [NUM_CH*DATA_W-1:0]     wdata_ip,
    input  logic [NUM_CH*(DATA_W/8)-1:0] be_ip,
    output logic [NUM_CH-1:0]            gnt_op,
    output logic [NUM_CH-1:0]            rvalid_op,
    output logic [DATA_W-1:0]            rdata_op,
    output logic                         mem_req_op,
    output logic                         mem_we_op,
    output logic [ADDR_W-1:0]            mem_addr_op,
    output logic [DATA_W-1:0]            mem_wdata_op,
    output logic [DATA_W/8-1:0]          mem_be_op,
    input  logic                         mem_rvalid_ip,
    input  logic [DATA_W-1:0]            mem_rdata_ip,
    output logic                         dbg_state_op,
    output logic [$clog2(NUM_CH)-1:0]    dbg_owner_op,
    output logic [$clog2(NUM_CH)-1:0]    dbg_ptr_op
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [PTR_W-1:0]   win;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last one written.
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_ip[i]) win = PTR_W'(i);
        end
    end

    assign dbg_ptr_op = '0;
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (!found && req_ip[idx]) begin
                win   = PTR_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign dbg_ptr_op = ptr_q;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rdata_d      = rdata_q;
        gnt_op       = '0;
        rvalid_op    = '0;
        rdata_op     = rdata_q;
        mem_req_op   = 1'b0;
        mem_we_op    = 1'b0;
        mem_addr_op  = '0;
        mem_wdata_op = '0;
        mem_be_op    = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_ip) begin
                    gnt_op[win]  = 1'b1;
                    mem_req_op   = 1'b1;
                    mem_we_op    = we_ip[win];
                    mem_addr_op  = addr_ip[win*ADDR_W +: ADDR_W];
                    mem_wdata_op = wdata_ip[win*DATA_W +: DATA_W];
                    mem_be_op    = be_ip[win*BE_W +: BE_W];
                    owner_d      = win;
                    state_d      = WAIT;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    ptr_d        = (win == PTR_W'(NUM_CH - 1)) ? '0 : win + PTR_W'(1);
`endif
                end
            end
            WAIT: begin
                if (mem_rvalid_ip) begin
                    rvalid_op[owner_q] = 1'b1;
                    rdata_op           = mem_rdata_ip;
                    rdata_d            = mem_rdata_ip;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset is synchronous, so outputs are forced quiet for the whole reset cycle.
        if (reset) begin
            gnt_op       = '0;
            rvalid_op    = '0;
            rdata_op     = '0;
            mem_req_op   = 1'b0;
            mem_we_op    = 1'b0;
            mem_addr_op  = '0;
            mem_wdata_op = '0;
            mem_be_op    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign dbg_state_op = logic'(state_q);
    assign dbg_owner_op = owner_q;
endmodule
